// File: rtl/cmp_rr_arbiter.sv
// Round-robin front end for one shared branch comparator. N_REQ requesters
// compete for it, and each result comes back one cycle later with the requester id and tag.

module cmp_rr_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic        taken,
  output logic        illegal
);
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: illegal = 1'b1;
    endcase
  end
endmodule

module cmp_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*32-1:0]    i_req_a,
  input  logic [N_REQ*32-1:0]    i_req_b,
  input  logic [N_REQ*3-1:0]     i_req_cmpop,
  input  logic [N_REQ*TAG_W-1:0] i_req_tag,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_rsp_valid,
  output logic                   o_rsp_taken,
  output logic                   o_rsp_illegal,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [TAG_W-1:0]       o_rsp_tag,
  input  logic                   i_rsp_ready
);
  logic [N_REQ-1:0][31:0]    req_a, req_b;
  logic [N_REQ-1:0][2:0]     req_op;
  logic [N_REQ-1:0][TAG_W-1:0] req_tag;

  assign req_a   = i_req_a;
  assign req_b   = i_req_b;
  assign req_op  = i_req_cmpop;
  assign req_tag = i_req_tag;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_taken_q, rsp_taken_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic            free, gnt_found, accept;
  logic [ID_W-1:0] gnt_id, idx;
  logic            cmp_taken, cmp_illegal;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    free        = !rsp_valid_q || i_rsp_ready;
    gnt_found   = 1'b0;
    gnt_id      = '0;
    idx         = '0;
    o_req_ready = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((32'(ptr_q) + 32'(i)) % N_REQ);
      if (!gnt_found && i_req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
    if (gnt_found && free) o_req_ready[gnt_id] = 1'b1;
    accept = gnt_found && free;
  end

  cmp_rr_cmp u_cmp (
    .a       (req_a[gnt_id]),
    .b       (req_b[gnt_id]),
    .op      (req_op[gnt_id]),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // A new accept overwrites a response draining in the same cycle.
  always_comb begin
    ptr_d         = ptr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_id_d      = rsp_id_q;
    rsp_tag_d     = rsp_tag_q;
    if (accept) begin
      ptr_d         = gnt_id;
      rsp_valid_d   = 1'b1;
      rsp_taken_d   = cmp_taken && !cmp_illegal;
      rsp_illegal_d = cmp_illegal;
      rsp_id_d      = gnt_id;
      rsp_tag_d     = req_tag[gnt_id];
    end else if (i_rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q         <= ID_W'(N_REQ - 1);
      rsp_valid_q   <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_id_q      <= '0;
      rsp_tag_q     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tag_q     <= rsp_tag_d;
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_taken   = rsp_taken_q;
  assign o_rsp_illegal = rsp_illegal_q;
  assign o_rsp_id      = rsp_id_q;
  assign o_rsp_tag     = rsp_tag_q;
endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Directed checks for cmp_rr_arbiter, followed by a short randomized run
// that is compared against a reference model.

module tb_cmp_rr_arbiter;
  localparam int N  = 2;
  localparam int TW = 4;
  localparam int IW = 1;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BLTU = 3'b110;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N*3-1:0]  req_op;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_taken, rsp_illegal, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [TW-1:0]   rsp_tag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_rr_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .i_req_cmpop(req_op), .i_req_tag(req_tag), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_taken(rsp_taken), .o_rsp_illegal(rsp_illegal),
    .o_rsp_id(rsp_id), .o_rsp_tag(rsp_tag), .i_rsp_ready(rsp_ready)
  );

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic chk_rsp(input string t, input logic v, input logic tk, input logic il,
                         input logic [IW-1:0] id, input logic [TW-1:0] tg);
    chk({t, ".valid"}, 64'(rsp_valid), 64'(v));
    chk({t, ".taken"}, 64'(rsp_taken), 64'(tk));
    chk({t, ".illegal"}, 64'(rsp_illegal), 64'(il));
    chk({t, ".id"}, 64'(rsp_id), 64'(id));
    chk({t, ".tag"}, 64'(rsp_tag), 64'(tg));
  endtask

  task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [TW-1:0] tg);
    req_valid[k]          = v;
    req_a[k*32 +: 32]     = a;
    req_b[k*32 +: 32]     = b;
    req_op[k*3 +: 3]      = op;
    req_tag[k*TW +: TW]   = tg;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference comparator: returns {illegal, taken}.
  function automatic logic [1:0] ref_cmp(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: ref_cmp = {1'b0, a == b};
      3'd1: ref_cmp = {1'b0, a != b};
      3'd4: ref_cmp = {1'b0, sa < sb};
      3'd5: ref_cmp = {1'b0, sa >= sb};
      3'd6: ref_cmp = {1'b0, a < b};
      3'd7: ref_cmp = {1'b0, a >= b};
      default: ref_cmp = 2'b10;
    endcase
  endfunction

  // Model state for the random phase.
  logic            m_vld, m_tk, m_il;
  logic [IW-1:0]   m_ptr, m_id;
  logic [TW-1:0]   m_tag;
  logic            m_free, m_found;
  int              m_g, m_idx;
  logic [1:0]      m_res;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    #3;
    chk_rsp("reset", 1'b0, 1'b0, 1'b0, 1'd0, 4'd0);
    chk("reset.ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-stream: hold a response from req0 (ptr becomes 0), then reset.
    set_req(0, 1'b1, 32'd5, 32'd5, BEQ, 4'd1);
    #1 chk("t1.grant0", 64'(req_ready), 64'(2'b01));
    tick;
    chk_rsp("t1.held", 1'b1, 1'b1, 1'b0, 1'd0, 4'd1);
    set_req(1, 1'b1, 32'd1, 32'd2, BNE, 4'd2);
    #1 chk("t1.backpressure", 64'(req_ready), 64'(0));
    #1 rst = 1'b1;
    #1 chk("t1.rst_valid", 64'(rsp_valid), 64'(0));
    chk("t1.rst_prio", 64'(req_ready), 64'(2'b01));
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick;
    chk_rsp("t1.first", 1'b1, 1'b1, 1'b0, 1'd0, 4'd1);
    req_valid = '0;
    tick;
    chk("t1.drain", 64'(rsp_valid), 64'(0));

    // BLT vs BLTU on -1 and 1.
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, BLT, 4'd5);
    #1 chk("t2.ready", 64'(req_ready), 64'(2'b01));
    tick;
    chk_rsp("t2.blt", 1'b1, 1'b1, 1'b0, 1'd0, 4'd5);
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, BLTU, 4'd5);
    tick;
    chk_rsp("t2.bltu", 1'b1, 1'b0, 1'b0, 1'd0, 4'd5);
    req_valid = '0;
    tick;
    chk("t2.drain", 64'(rsp_valid), 64'(0));

    // Both valid continuously: last winner was 0, so grants go 1,0,1,0.
    set_req(0, 1'b1, 32'd3, 32'd3, BEQ, 4'd3);
    set_req(1, 1'b1, 32'd3, 32'd3, BNE, 4'd9);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3.grant", 64'(req_ready), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      tick;
      if (i % 2 == 0) chk_rsp("t3.rsp1", 1'b1, 1'b0, 1'b0, 1'd1, 4'd9);
      else            chk_rsp("t3.rsp0", 1'b1, 1'b1, 1'b0, 1'd0, 4'd3);
    end

    // Backpressure for 3 cycles, then drain + accept together.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4.ready", 64'(req_ready), 64'(0));
      tick;
      chk_rsp("t4.hold", 1'b1, 1'b1, 1'b0, 1'd0, 4'd3);
    end
    rsp_ready = 1'b1;
    #1 chk("t4.regrant", 64'(req_ready), 64'(2'b10));
    tick;
    chk_rsp("t4.replace", 1'b1, 1'b0, 1'b0, 1'd1, 4'd9);
    req_valid = '0;
    tick;
    chk("t4.drain", 64'(rsp_valid), 64'(0));

    // Illegal op from req1, then a legal BEQ.
    set_req(1, 1'b1, 32'd1, 32'd1, 3'b010, 4'hA);
    tick;
    chk_rsp("t5.illegal", 1'b1, 1'b0, 1'b1, 1'd1, 4'hA);
    set_req(1, 1'b1, 32'd7, 32'd7, BEQ, 4'hB);
    tick;
    chk_rsp("t5.beq", 1'b1, 1'b1, 1'b0, 1'd1, 4'hB);
    req_valid = '0;
    tick;
    chk("t5.drain", 64'(rsp_valid), 64'(0));

    // Random traffic against the model; requesters hold until handshake.
    m_ptr = 1'd1; m_vld = 1'b0; m_tk = 1'b0; m_il = 1'b0; m_id = '0; m_tag = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
          logic [31:0] rb;
          rb = $urandom();
          set_req(k, 1'b1, ($urandom_range(0, 2) == 0) ? rb : $urandom(), rb,
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
      end
      m_free  = !m_vld || rsp_ready;
      m_found = 1'b0;
      m_g     = 0;
      for (int i = 1; i <= N; i++) begin
        m_idx = (int'(m_ptr) + i) % N;
        if (!m_found && req_valid[m_idx]) begin
          m_found = 1'b1;
          m_g     = m_idx;
        end
      end
      #1 chk("rnd.ready", 64'(req_ready), (m_found && m_free) ? 64'(1) << m_g : 64'(0));
      @(posedge clk);
      if (m_found && m_free) begin
        m_res = ref_cmp(req_op[m_g*3 +: 3], req_a[m_g*32 +: 32], req_b[m_g*32 +: 32]);
        m_vld = 1'b1;
        m_il  = m_res[1];
        m_tk  = m_res[0];
        m_id  = IW'(m_g);
        m_tag = req_tag[m_g*TW +: TW];
        m_ptr = IW'(m_g);
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
      #1;
      if (m_found && m_free) req_valid[m_g] = 1'b0;
      chk("rnd.valid", 64'(rsp_valid), 64'(m_vld));
      if (m_vld) chk_rsp("rnd.rsp", 1'b1, m_tk, m_il, m_id, m_tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
